ext_mem_model: RTL and testbench

EXT_MEM_MODEL -- requirements
Module: ext_mem_model

---
 rtl/ext_mem_model_pkg.sv | 14 +
 rtl/ext_mem_model.sv | 154 +++++++++++++++
 tb/tb_ext_mem_model.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_mem_model_pkg.sv
// Shared memory-interface constants for the processor and its external memory model.
package ext_mem_model_pkg;

  localparam int CFG_MEM_ADDR_BITS = 28;
  localparam int CFG_MEM_DATA_BITS = 128;
  localparam int CFG_MEM_TAG_BITS  = 5;
  localparam int CFG_DATA_CYCLES   = 4;

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ext_mem_model.sv
// Beat-addressed external memory model: one outstanding cache-line read or masked write
// at a time, fixed read latency, registered response channel with no backpressure.
module ext_mem_model
  import ext_mem_model_pkg::*;
#(
  parameter int MEM_ADDR_BITS = CFG_MEM_ADDR_BITS,
  parameter int MEM_DATA_BITS = CFG_MEM_DATA_BITS,
  parameter int MEM_TAG_BITS  = CFG_MEM_TAG_BITS,
  parameter int DATA_CYCLES   = CFG_DATA_CYCLES,
  parameter int RAM_DEPTH     = 65536,
  parameter int READ_LATENCY  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mem_req_valid,
  output logic                       mem_req_ready,
  input  logic                       mem_req_rw,
  input  logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
  input  logic [MEM_TAG_BITS-1:0]    mem_req_tag,
  input  logic                       mem_req_data_valid,
  output logic                       mem_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
  input  logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
  output logic                       mem_resp_valid,
  output logic [MEM_DATA_BITS-1:0]   mem_resp_data,
  output logic [MEM_TAG_BITS-1:0]    mem_resp_tag
);

  typedef enum logic [1:0] {IDLE, WDATA, RWAIT, RRESP} state_e;

  localparam int NBYTES = MEM_DATA_BITS / 8;
  localparam int CNT_W  = clog2_min1(DATA_CYCLES);
  localparam int LAT_W  = clog2_min1(READ_LATENCY);
  localparam int IDX_W  = clog2_min1(RAM_DEPTH);

  localparam logic [MEM_ADDR_BITS-1:0] LINE_MASK = ~MEM_ADDR_BITS'(DATA_CYCLES - 1);
  localparam logic [CNT_W-1:0]         LAST_BEAT = CNT_W'(DATA_CYCLES - 1);
  localparam logic [LAT_W-1:0]         LAST_WAIT = LAT_W'(READ_LATENCY - 1);

  logic [MEM_DATA_BITS-1:0] ram [0:RAM_DEPTH-1];

  state_e                   state_q, state_d;
  logic [MEM_ADDR_BITS-1:0] base_q, base_d;
  logic [MEM_TAG_BITS-1:0]  tag_q, tag_d;
  logic [CNT_W-1:0]         beat_q, beat_d;
  logic [LAT_W-1:0]         lat_q, lat_d;
  logic                     ready_q, ready_d;
  logic                     data_ready_q, data_ready_d;
  logic                     resp_valid_q, resp_valid_d;
  logic [MEM_DATA_BITS-1:0] resp_data_q, resp_data_d;
  logic [MEM_TAG_BITS-1:0]  resp_tag_q, resp_tag_d;

  logic [MEM_ADDR_BITS-1:0] beat_addr;
  logic [IDX_W-1:0]         ram_idx;
  logic                     wr_en;

  // Line base has its low bits cleared, so OR-ing the beat number is base + k.
  assign beat_addr = base_q | MEM_ADDR_BITS'(beat_q);
  assign ram_idx   = IDX_W'(beat_addr % MEM_ADDR_BITS'(RAM_DEPTH));
  assign wr_en     = data_ready_q & mem_req_data_valid;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    tag_d        = tag_q;
    beat_d       = beat_q;
    lat_d        = lat_q;
    resp_valid_d = 1'b0;
    resp_data_d  = '0;
    resp_tag_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (mem_req_valid && ready_q) begin
          base_d  = mem_req_addr & LINE_MASK;
          tag_d   = mem_req_tag;
          beat_d  = '0;
          lat_d   = '0;
          state_d = mem_req_rw ? WDATA : RWAIT;
        end
      end
      WDATA: begin
        if (mem_req_data_valid) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      RWAIT, RRESP: begin
        // RWAIT counts down the latency, then both states stream one beat per cycle.
        if (state_q == RWAIT && lat_q != LAST_WAIT) begin
          lat_d = lat_q + LAT_W'(1);
        end else begin
          resp_valid_d = 1'b1;
          resp_data_d  = ram[ram_idx];
          resp_tag_d   = tag_q;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + CNT_W'(1);
            state_d = RRESP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_d      = (state_d == IDLE);
  assign data_ready_d = (state_d == WDATA);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      lat_q        <= '0;
      ready_q      <= 1'b1;
      data_ready_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      tag_q        <= tag_d;
      beat_q       <= beat_d;
      lat_q        <= lat_d;
      ready_q      <= ready_d;
      data_ready_q <= data_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_tag_q   <= resp_tag_d;
    end
  end

  // Storage is never reset; a write beat coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (mem_req_data_mask[i]) ram[ram_idx][8*i +: 8] <= mem_req_data_bits[8*i +: 8];
      end
    end
  end

  assign mem_req_ready      = ready_q;
  assign mem_req_data_ready = data_ready_q;
  assign mem_resp_valid     = resp_valid_q;
  assign mem_resp_data      = resp_data_q;
  assign mem_resp_tag       = resp_tag_q;

endmodule

// File: tb/tb_ext_mem_model.sv
// Randomized bench for ext_mem_model against an associative-array memory model.
module tb_ext_mem_model;

  localparam int AW = 28, DW = 128, TW = 5, DC = 4, DEPTH = 65536, LAT = 2;

  logic          clk = 1'b0, reset = 1'b0;
  logic          mem_req_valid = 1'b0, mem_req_rw = 1'b0, mem_req_data_valid = 1'b0;
  logic [AW-1:0] mem_req_addr = '0;
  logic [TW-1:0] mem_req_tag = '0;
  logic [DW-1:0] mem_req_data_bits = '0;
  logic [15:0]   mem_req_data_mask = '0;
  logic          mem_req_ready, mem_req_data_ready, mem_resp_valid;
  logic [DW-1:0] mem_resp_data;
  logic [TW-1:0] mem_resp_tag;

  always #5 clk = ~clk;

  ext_mem_model #(.MEM_ADDR_BITS(AW), .MEM_DATA_BITS(DW), .MEM_TAG_BITS(TW),
                  .DATA_CYCLES(DC), .RAM_DEPTH(DEPTH), .READ_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_tag(mem_resp_tag)
  );

  int checks = 0, failures = 0;
  logic [DW-1:0] mdl [int];
  logic [DW-1:0] wd [4];
  logic [15:0]   wm [4];
  int            gap_max = 0;
  logic [DW-1:0] r_data [4];
  logic [TW-1:0] r_tag [4];
  int            r_nb, r_first;
  logic          r_gap, r_idle_bad;

  function automatic logic [DW-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int idx_of(input logic [AW-1:0] a, input int k);
    return ((int'(a) & ~(DC - 1)) + k) % DEPTH;
  endfunction

  function automatic logic [DW-1:0] exp_beat(input logic [AW-1:0] a, input int k);
    return mdl.exists(idx_of(a, k)) ? mdl[idx_of(a, k)] : '0;
  endfunction

  task automatic wait_ready(input string who);
    int n = 0;
    while (mem_req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (mem_req_ready !== 1'b1) begin
      failures++; $display("FAIL %s_ready_timeout got=%b want=1", who, mem_req_ready);
    end
  endtask

  task automatic model_write(input logic [AW-1:0] a, input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      logic [DW-1:0] cur = exp_beat(a, k);
      for (int b = 0; b < 16; b++) if (wm[k][b]) cur[8*b +: 8] = wd[k][8*b +: 8];
      mdl[idx_of(a, k)] = cur;
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [TW-1:0] t);
    wait_ready("wr");
    mem_req_valid = 1'b1; mem_req_rw = 1'b1; mem_req_addr = a; mem_req_tag = t;
    @(negedge clk);
    mem_req_valid = 1'b0; mem_req_rw = 1'($urandom); mem_req_addr = AW'($urandom);
    for (int k = 0; k < DC; k++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      mem_req_data_valid = 1'b1; mem_req_data_bits = wd[k]; mem_req_data_mask = wm[k];
      @(negedge clk);
      mem_req_data_valid = 1'b0; mem_req_data_bits = rand128();
    end
    model_write(a, DC);
  endtask

  task automatic fill_line(input logic [AW-1:0] a);
    for (int k = 0; k < DC; k++) begin wd[k] = rand128(); wm[k] = 16'hFFFF; end
    do_write(a, TW'($urandom));
  endtask

  // Sample index j counts cycles after the acceptance edge; beat 0 is due at j == LAT.
  task automatic do_read(input logic [AW-1:0] a, input logic [TW-1:0] t);
    int prev = 0;
    wait_ready("rd");
    mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = a; mem_req_tag = t;
    @(negedge clk);
    mem_req_valid = 1'b0; mem_req_addr = AW'($urandom); mem_req_tag = TW'($urandom);
    r_nb = 0; r_first = -1; r_gap = 1'b0; r_idle_bad = 1'b0;
    for (int j = 0; j < 20; j++) begin
      if (j > 0) @(negedge clk);
      if (mem_resp_valid) begin
        if (r_nb < 4) begin r_data[r_nb] = mem_resp_data; r_tag[r_nb] = mem_resp_tag; end
        if (r_nb == 0) r_first = j;
        else if (j != prev + 1) r_gap = 1'b1;
        prev = j; r_nb++;
      end else if (mem_resp_data !== '0 || mem_resp_tag !== '0) r_idle_bad = 1'b1;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (mem_req_ready !== 1'b1 || mem_req_data_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready got=%b/%b want=1/0", mem_req_ready, mem_req_data_ready);
    end
    checks++;
    if (mem_resp_valid !== 1'b0 || mem_resp_data !== '0 || mem_resp_tag !== '0) begin
      failures++; $display("FAIL reset_resp got=%b/%h/%h want=0/0/0", mem_resp_valid, mem_resp_data, mem_resp_tag);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req_ready !== 1'b1 || mem_resp_valid !== 1'b0) begin
      failures++; $display("FAIL post_reset got=%b/%b want=1/0", mem_req_ready, mem_resp_valid);
    end
  endtask

  task automatic test_preload_read();
    for (int k = 0; k < DC; k++) begin wd[k] = {rand128() >> 8, 8'(k)}; wm[k] = 16'hFFFF; end
    do_write('h0, 5'd0);
    do_read('h0, 5'd5);
    checks++;
    if (r_nb !== 4 || r_first !== LAT || r_gap !== 1'b0) begin
      failures++; $display("FAIL preload_timing got nb=%0d first=%0d gap=%b want nb=4 first=%0d gap=0", r_nb, r_first, r_gap, LAT);
    end
    checks++;
    if (r_idle_bad !== 1'b0) begin failures++; $display("FAIL preload_idle_zero got=%b want=0", r_idle_bad); end
    for (int k = 0; k < DC; k++) begin
      checks++;
      if (r_data[k][7:0] !== 8'(k) || r_data[k] !== wd[k] || r_tag[k] !== 5'd5) begin
        failures++; $display("FAIL preload_beat%0d got=%h tag=%0d want=%h tag=5", k, r_data[k], r_tag[k], wd[k]);
      end
    end
  endtask

  task automatic test_full_write();
    for (int k = 0; k < DC; k++) begin wd[k] = '1; wm[k] = 16'hFFFF; end
    gap_max = 2;
    do_write('h4, 5'd1);
    gap_max = 0;
    do_read('h6, 5'd9);
    checks++;
    if (r_nb !== 4) begin failures++; $display("FAIL full_write_nb got=%0d want=4", r_nb); end
    for (int k = 0; k < DC; k++) begin
      checks++;
      if (r_data[k] !== {DW{1'b1}} || r_tag[k] !== 5'd9) begin
        failures++; $display("FAIL full_write_beat%0d got=%h tag=%0d want=all-ones tag=9", k, r_data[k], r_tag[k]);
      end
    end
  endtask

  task automatic test_mask();
    logic [DW-1:0] old [4];
    for (int k = 0; k < DC; k++) begin old[k] = exp_beat('h0, k); wd[k] = rand128(); wm[k] = 16'h0000; end
    wd[0] = 128'hAB; wm[0] = 16'h0001;
    do_write('h0, 5'd2);
    do_read('h0, 5'd3);
    checks++;
    if (r_data[0] !== {old[0][DW-1:8], 8'hAB}) begin
      failures++; $display("FAIL mask_byte0 got=%h want=%h", r_data[0], {old[0][DW-1:8], 8'hAB});
    end
    for (int k = 1; k < DC; k++) begin
      checks++;
      if (r_data[k] !== old[k]) begin failures++; $display("FAIL mask_untouched%0d got=%h want=%h", k, r_data[k], old[k]); end
    end
    fill_line('h20);
    for (int k = 0; k < DC; k++) begin wd[k] = rand128(); wm[k] = 16'($urandom); end
    do_write('h21, 5'd4);
    do_read('h20, 5'd4);
    for (int k = 0; k < DC; k++) begin
      checks++;
      if (r_data[k] !== exp_beat('h20, k)) begin
        failures++; $display("FAIL mask_random%0d got=%h want=%h", k, r_data[k], exp_beat('h20, k));
      end
    end
  endtask

  task automatic test_stray();
    checks++;
    if (mem_req_data_ready !== 1'b0) begin failures++; $display("FAIL stray_data_ready got=%b want=0", mem_req_data_ready); end
    mem_req_data_valid = 1'b1; mem_req_data_mask = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin mem_req_data_bits = rand128(); @(negedge clk); end
    mem_req_data_valid = 1'b0;
    do_read('h20, 5'd6);
    for (int k = 0; k < DC; k++) begin
      checks++;
      if (r_data[k] !== exp_beat('h20, k)) begin
        failures++; $display("FAIL stray_ignored%0d got=%h want=%h", k, r_data[k], exp_beat('h20, k));
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0, nb = 0;
    int acc_j [2];
    logic pend = 1'b0, rdy_last = 1'b0;
    logic [DW-1:0] got [8];
    logic [TW-1:0] gt [8];
    wait_ready("b2b");
    mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = 'h0; mem_req_tag = 5'd3;
    for (int j = 0; j < 40; j++) begin
      if (j > 0) @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        if (acc == 1) begin mem_req_addr = 'h4; mem_req_tag = 5'd7; end
        else mem_req_valid = 1'b0;
      end
      if (mem_resp_valid) begin
        if (nb < 8) begin got[nb] = mem_resp_data; gt[nb] = mem_resp_tag; end
        if (nb == 3) rdy_last = mem_req_ready;
        nb++;
      end
      if (mem_req_valid && mem_req_ready) begin
        if (acc < 2) acc_j[acc] = j;
        acc++; pend = 1'b1;
      end
    end
    mem_req_valid = 1'b0;
    checks++;
    if (acc !== 2 || nb !== 8) begin failures++; $display("FAIL b2b_counts got acc=%0d beats=%0d want acc=2 beats=8", acc, nb); end
    checks++;
    if (acc == 2 && (acc_j[1] - acc_j[0] !== LAT + 4 || rdy_last !== 1'b1)) begin
      failures++; $display("FAIL b2b_ready_gap got=%0d rdy_last=%b want=%0d rdy_last=1", acc_j[1] - acc_j[0], rdy_last, LAT + 4);
    end
    for (int k = 0; k < 8 && k < nb; k++) begin
      checks++;
      if (got[k] !== exp_beat(k < 4 ? 'h0 : 'h4, k % 4) || gt[k] !== (k < 4 ? 5'd3 : 5'd7)) begin
        failures++; $display("FAIL b2b_beat%0d got=%h tag=%0d want=%h", k, got[k], gt[k], exp_beat(k < 4 ? 'h0 : 'h4, k % 4));
      end
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < DC; k++) begin wd[k] = rand128(); wm[k] = 16'hFFFF; end
    do_write(AW'(DEPTH + 8), 5'd6);
    do_read('h8, 5'd7);
    for (int k = 0; k < DC; k++) begin
      checks++;
      if (r_data[k] !== wd[k]) begin failures++; $display("FAIL wrap_beat%0d got=%h want=%h", k, r_data[k], wd[k]); end
    end
    do_read(AW'(3 * DEPTH + 9), 5'd8);
    checks++;
    if (r_data[1] !== wd[1] || r_tag[1] !== 5'd8) begin
      failures++; $display("FAIL wrap_alias got=%h want=%h", r_data[1], wd[1]);
    end
  endtask

  task automatic test_reset_mid();
    fill_line('h40);
    fill_line('h44);
    for (int k = 0; k < DC; k++) begin wd[k] = rand128(); wm[k] = 16'hFFFF; end
    wait_ready("rst_wr");
    mem_req_valid = 1'b1; mem_req_rw = 1'b1; mem_req_addr = 'h41; mem_req_tag = 5'd4;
    @(negedge clk);
    mem_req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mem_req_data_valid = 1'b1; mem_req_data_bits = wd[k]; mem_req_data_mask = 16'hFFFF;
      if (k == 2) reset = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (mem_req_ready !== 1'b1 || mem_req_data_ready !== 1'b0 || mem_resp_valid !== 1'b0) begin
      failures++; $display("FAIL rst_wr_flags got=%b/%b/%b want=1/0/0", mem_req_ready, mem_req_data_ready, mem_resp_valid);
    end
    reset = 1'b1; mem_req_data_bits = wd[3];
    @(negedge clk);
    mem_req_data_valid = 1'b0;
    model_write('h40, 2);
    do_read('h40, 5'd10);
    for (int k = 0; k < DC; k++) begin
      checks++;
      if (r_data[k] !== exp_beat('h40, k)) begin
        failures++; $display("FAIL rst_wr_beat%0d got=%h want=%h", k, r_data[k], exp_beat('h40, k));
      end
    end
    do_read('h44, 5'd11);
    checks++;
    if (r_data[0] !== exp_beat('h44, 0) || r_data[3] !== exp_beat('h44, 3)) begin
      failures++; $display("FAIL rst_neighbour got=%h want=%h", r_data[0], exp_beat('h44, 0));
    end
    wait_ready("rst_rd");
    mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = 'h44; mem_req_tag = 5'd12;
    @(negedge clk);
    mem_req_valid = 1'b0;
    repeat (LAT) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_resp_valid !== 1'b0 || mem_resp_data !== '0 || mem_resp_tag !== '0 || mem_req_ready !== 1'b1) begin
      failures++; $display("FAIL rst_rd_clear got=%b/%h/%h/%b want=0/0/0/1", mem_resp_valid, mem_resp_data, mem_resp_tag, mem_req_ready);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) fill_line(AW'('h100 + 4 * i));
    gap_max = 2;
    for (int n = 0; n < 24; n++) begin
      logic [AW-1:0] a = AW'('h100 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3) + DEPTH * $urandom_range(0, 15));
      logic [TW-1:0] t = TW'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < DC; k++) begin
          wd[k] = rand128(); wm[k] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        end
        do_write(a, t);
      end else begin
        do_read(a, t);
        checks++;
        if (r_nb !== 4 || r_first !== LAT || r_gap !== 1'b0 || r_idle_bad !== 1'b0) begin
          failures++; $display("FAIL rand_timing%0d got nb=%0d first=%0d gap=%b idle=%b want 4/%0d/0/0", n, r_nb, r_first, r_gap, r_idle_bad, LAT);
        end
        for (int k = 0; k < DC; k++) begin
          checks++;
          if (r_data[k] !== exp_beat(a, k) || r_tag[k] !== t) begin
            failures++; $display("FAIL rand_read%0d_beat%0d got=%h tag=%0d want=%h tag=%0d", n, k, r_data[k], r_tag[k], exp_beat(a, k), t);
          end
        end
      end
    end
    gap_max = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_preload_read();
    test_full_write();
    test_mask();
    test_stray();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
